// File: rtl/inst_mem_loadable_pkg.sv
// Shared sizing helpers, FSM encoding and default NOP for the loadable instruction memory.
package inst_mem_loadable_pkg;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } mem_state_t;

   function automatic int calc_bpw(input int word_size, input int cell_size);
      return word_size / cell_size;
   endfunction

   function automatic int calc_depth(input int mem_size, input int word_size, input int cell_size);
      return mem_size / calc_bpw(word_size, cell_size);
   endfunction

   // Word-index width: byte-address bits inside the memory minus the byte-offset bits.
   function automatic int calc_idx_w(input int mem_size, input int word_size, input int cell_size);
      return $clog2(mem_size) - $clog2(calc_bpw(word_size, cell_size));
   endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-write, single-read word array; a same-cycle write to the read index is forwarded.
module inst_mem_array #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/inst_mem_loadable.sv
// Clocked instruction memory with a program-load port, post-reset clear sweep and
// a registered fetch port (stall/flush, address-fault flag) feeding the IF/ID register.
module inst_mem_loadable
   import inst_mem_loadable_pkg::*;
#(
   parameter int                     WORD_SIZE      = 32,
   parameter int                     MEM_CELL_SIZE  = 8,
   parameter int                     MEM_SIZE       = 1024,
   parameter logic [WORD_SIZE-1:0]   NOP_WORD       = WORD_SIZE'(NOP_DEFAULT),
   parameter bit                     CLEAR_ON_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_en,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [WORD_SIZE-1:0] addr,
   output logic [WORD_SIZE-1:0] instruction,
   output logic                 inst_valid,
   output logic                 addr_fault,
   input  logic                 ld_en,
   input  logic [WORD_SIZE-1:0] ld_addr,
   input  logic [WORD_SIZE-1:0] ld_data,
   output logic                 ld_ready
);

   localparam int BPW   = calc_bpw(WORD_SIZE, MEM_CELL_SIZE);
   localparam int DEPTH = calc_depth(MEM_SIZE, WORD_SIZE, MEM_CELL_SIZE);
   localparam int IW    = calc_idx_w(MEM_SIZE, WORD_SIZE, MEM_CELL_SIZE);
   localparam int OFF_W = $clog2(BPW);
   localparam int MA_W  = $clog2(MEM_SIZE);

   // Full-width unsigned compare so addresses above the memory never alias into it.
   function automatic logic addr_ok(input logic [WORD_SIZE-1:0] a);
      return (a[OFF_W-1:0] == '0) && (a < WORD_SIZE'(MEM_SIZE));
   endfunction

   mem_state_t           state;
   logic [IW-1:0]        clr_cnt;
   logic                 ld_ready_r;
   logic [WORD_SIZE-1:0] inst_p1;
   logic                 vld_p1;
   logic                 fault_p1;

   logic                 clearing;
   logic                 we;
   logic [IW-1:0]        waddr;
   logic [WORD_SIZE-1:0] wdata;
   logic [WORD_SIZE-1:0] rdata_p0;

   assign clearing = (state == ST_CLEAR);
   assign we       = !rst && (clearing || (ld_en && addr_ok(ld_addr)));
   assign waddr    = clearing ? clr_cnt : ld_addr[MA_W-1:OFF_W];
   assign wdata    = clearing ? NOP_WORD : ld_data;

   inst_mem_array #(
      .WIDTH (WORD_SIZE),
      .DEPTH (DEPTH),
      .AW    (IW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (addr[MA_W-1:OFF_W]),
      .rdata (rdata_p0)
   );

   // Stage p0 -> p1: FSM, sweep counter and fetch output register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_cnt    <= '0;
         ld_ready_r <= !CLEAR_ON_RESET;
         inst_p1    <= NOP_WORD;
         vld_p1     <= 1'b0;
         fault_p1   <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == IW'(DEPTH - 1)) begin
                  state      <= ST_READY;
                  ld_ready_r <= 1'b1;
               end
            end
            default: begin
               if (flush) begin
                  inst_p1  <= NOP_WORD;
                  vld_p1   <= 1'b0;
                  fault_p1 <= 1'b0;
               end else if (!stall) begin
                  if (fetch_en && addr_ok(addr)) begin
                     inst_p1  <= rdata_p0;
                     vld_p1   <= 1'b1;
                     fault_p1 <= 1'b0;
                  end else if (fetch_en) begin
                     inst_p1  <= NOP_WORD;
                     vld_p1   <= 1'b0;
                     fault_p1 <= 1'b1;
                  end else begin
                     vld_p1   <= 1'b0;
                     fault_p1 <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign instruction = inst_p1;
   assign inst_valid  = vld_p1;
   assign addr_fault  = fault_p1;
   assign ld_ready    = ld_ready_r;

endmodule
